// File: rtl/axil_sram_slave.sv
// AXI4-Lite slave backed by an internal word-addressed register array.
//
// Parameters:
//   DATA_W    data bus width (32 or 64)
//   ADDR_W    address bus width
//   DEPTH     number of DATA_W-bit words (power of two, >= 2)
//   BASE_ADDR byte address of word 0, aligned to DEPTH*DATA_W/8
//
// Ports:
//   ACLK, ARESETN                  clock, synchronous active-low reset
//   AR*/R*                         read address / read data channels
//   AW*/W*/B*                      write address / data / response channels
//
// Reads complete one cycle after the AR handshake. AW and W are captured in
// independent one-entry buffers; the write commits in the first cycle both
// are full. Out-of-range accesses return SLVERR (reads return zero data).
//
// Optional feature macro: AXIL_SRAM_PROT_CHECK_EN
//   When defined, any access with xPROT[1]=1 (non-secure) returns SLVERR and
//   the write is suppressed. When undefined, ARPROT/AWPROT are ignored.
module axil_sram_slave #(
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DEPTH     = 256,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000
) (
  input  logic                ACLK,
  input  logic                ARESETN,
  input  logic [ADDR_W-1:0]   ARADDR,
  input  logic [2:0]          ARPROT,
  input  logic                ARVALID,
  output logic                ARREADY,
  output logic [DATA_W-1:0]   RDATA,
  output logic [1:0]          RRESP,
  output logic                RVALID,
  input  logic                RREADY,
  input  logic [ADDR_W-1:0]   AWADDR,
  input  logic [2:0]          AWPROT,
  input  logic                AWVALID,
  output logic                AWREADY,
  input  logic [DATA_W-1:0]   WDATA,
  input  logic [DATA_W/8-1:0] WSTRB,
  input  logic                WVALID,
  output logic                WREADY,
  output logic [1:0]          BRESP,
  output logic                BVALID,
  input  logic                BREADY
);

  localparam int unsigned       StrbW     = DATA_W / 8;
  localparam int unsigned       AddrLsb   = $clog2(StrbW);
  localparam int unsigned       IdxW      = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] SpanBytes = ADDR_W'(DEPTH * StrbW);
  localparam logic [1:0]        RespOkay  = 2'b00;
  localparam logic [1:0]        RespSlvErr = 2'b10;

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Read channel state
  logic              rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q,  rdata_d;
  logic [1:0]        rresp_q,  rresp_d;

  // Write holding buffers and response state
  logic              aw_full_q, aw_full_d;
  logic [IdxW-1:0]   aw_idx_q,  aw_idx_d;
  logic              aw_err_q,  aw_err_d;
  logic              w_full_q,  w_full_d;
  logic [DATA_W-1:0] w_data_q,  w_data_d;
  logic [StrbW-1:0]  w_strb_q,  w_strb_d;
  logic              bvalid_q,  bvalid_d;
  logic [1:0]        bresp_q,   bresp_d;

  // Address decode. Unsigned wrap of the subtraction makes addresses below
  // BASE_ADDR compare as large offsets, so one compare covers both bounds.
  // BASE_ADDR is span-aligned, so the index bits equal those of the address.
  logic [ADDR_W-1:0] ar_off, aw_off;
  logic              ar_in_range, aw_in_range;
  logic              rd_err, wr_err;
  logic [IdxW-1:0]   ar_idx, aw_idx;
  logic              unused_prot;

  assign ar_off      = ARADDR - BASE_ADDR;
  assign aw_off      = AWADDR - BASE_ADDR;
  assign ar_in_range = ar_off < SpanBytes;
  assign aw_in_range = aw_off < SpanBytes;
  assign ar_idx      = ARADDR[AddrLsb +: IdxW];
  assign aw_idx      = AWADDR[AddrLsb +: IdxW];

`ifdef AXIL_SRAM_PROT_CHECK_EN
  assign rd_err      = !ar_in_range || ARPROT[1];
  assign wr_err      = !aw_in_range || AWPROT[1];
  assign unused_prot = ^{ARPROT[2], ARPROT[0], AWPROT[2], AWPROT[0]};
`else
  assign rd_err      = !ar_in_range;
  assign wr_err      = !aw_in_range;
  assign unused_prot = ^{ARPROT, AWPROT};
`endif

  // Handshakes
  logic ar_hs, aw_hs, w_hs, commit;

  assign ARREADY = !rvalid_q;
  assign AWREADY = !aw_full_q && !bvalid_q;
  assign WREADY  = !w_full_q && !bvalid_q;
  assign ar_hs   = ARVALID && ARREADY;
  assign aw_hs   = AWVALID && AWREADY;
  assign w_hs    = WVALID && WREADY;
  // Registered fullness only: a write never commits on the handshake edge.
  assign commit  = aw_full_q && w_full_q;

  assign RVALID = rvalid_q;
  assign RDATA  = rdata_q;
  assign RRESP  = rresp_q;
  assign BVALID = bvalid_q;
  assign BRESP  = bresp_q;

  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_err ? '0 : mem_q[ar_idx];
      rresp_d  = rd_err ? RespSlvErr : RespOkay;
    end else if (rvalid_q && RREADY) begin
      rvalid_d = 1'b0;
    end
  end

  always_comb begin
    aw_full_d = aw_full_q;
    aw_idx_d  = aw_idx_q;
    aw_err_d  = aw_err_q;
    w_full_d  = w_full_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    if (aw_hs) begin
      aw_full_d = 1'b1;
      aw_idx_d  = aw_idx;
      aw_err_d  = wr_err;
    end
    if (w_hs) begin
      w_full_d = 1'b1;
      w_data_d = WDATA;
      w_strb_d = WSTRB;
    end
    if (commit) begin
      // Buffers are full, so no handshake can coincide with the commit.
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = aw_err_q ? RespSlvErr : RespOkay;
    end else if (bvalid_q && BREADY) begin
      bvalid_d = 1'b0;
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RespOkay;
      aw_full_q <= 1'b0;
      aw_idx_q  <= '0;
      aw_err_q  <= 1'b0;
      w_full_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RespOkay;
    end else begin
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      aw_full_q <= aw_full_d;
      aw_idx_q  <= aw_idx_d;
      aw_err_q  <= aw_err_d;
      w_full_q  <= w_full_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
    end
  end

  // Array is not reset; a commit coinciding with reset is dropped.
  always_ff @(posedge ACLK) begin
    if (ARESETN && commit && !aw_err_q) begin
      for (int k = 0; k < int'(StrbW); k++) begin
        if (w_strb_q[k]) begin
          mem_q[aw_idx_q][k*8 +: 8] <= w_data_q[k*8 +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_axil_sram_slave.sv
module tb_axil_sram_slave;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic [31:0] ARADDR;
  logic [2:0]  ARPROT;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY;
  logic [31:0] AWADDR;
  logic [2:0]  AWPROT;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WVALID;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;

  axil_sram_slave #(
    .DATA_W    (32),
    .ADDR_W    (32),
    .DEPTH     (16),
    .BASE_ADDR (32'h8000_0000)
  ) u_dut (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .ARADDR  (ARADDR),
    .ARPROT  (ARPROT),
    .ARVALID (ARVALID),
    .ARREADY (ARREADY),
    .RDATA   (RDATA),
    .RRESP   (RRESP),
    .RVALID  (RVALID),
    .RREADY  (RREADY),
    .AWADDR  (AWADDR),
    .AWPROT  (AWPROT),
    .AWVALID (AWVALID),
    .AWREADY (AWREADY),
    .WDATA   (WDATA),
    .WSTRB   (WSTRB),
    .WVALID  (WVALID),
    .WREADY  (WREADY),
    .BRESP   (BRESP),
    .BVALID  (BVALID),
    .BREADY  (BREADY)
  );

  always #5 ACLK = ~ACLK;

  int tests = 0;
  int fails = 0;

  logic [31:0] rq_data [$];
  logic [1:0]  rq_resp [$];
  logic [1:0]  bq_resp [$];
  logic [31:0] mon_d;
  logic [1:0]  mon_r;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Scoreboard monitor: compares each R/B beat as it is accepted.
  always @(negedge ACLK) begin
    if (ARESETN === 1'b1 && RVALID && RREADY) begin
      if (rq_data.size() == 0) begin
        chk("r_unexpected", 32'd1, 32'd0);
      end else begin
        mon_d = rq_data.pop_front();
        mon_r = rq_resp.pop_front();
        chk("rdata", RDATA, mon_d);
        chk("rresp", {30'd0, RRESP}, {30'd0, mon_r});
      end
    end
    if (ARESETN === 1'b1 && BVALID && BREADY) begin
      if (bq_resp.size() == 0) begin
        chk("b_unexpected", 32'd1, 32'd0);
      end else begin
        mon_r = bq_resp.pop_front();
        chk("bresp", {30'd0, BRESP}, {30'd0, mon_r});
      end
    end
  end

  // All drivers are entered #1 after a rising edge and return likewise.
  task automatic do_aw(input logic [31:0] a, input logic [2:0] p);
    int n = 0;
    AWADDR = a; AWPROT = p; AWVALID = 1'b1;
    @(negedge ACLK);
    while (!AWREADY && n < 50) begin @(negedge ACLK); n++; end
    if (!AWREADY) chk("aw_ready_timeout", 32'd0, 32'd1);
    @(posedge ACLK); #1 AWVALID = 1'b0;
  endtask

  task automatic do_w(input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    WDATA = d; WSTRB = s; WVALID = 1'b1;
    @(negedge ACLK);
    while (!WREADY && n < 50) begin @(negedge ACLK); n++; end
    if (!WREADY) chk("w_ready_timeout", 32'd0, 32'd1);
    @(posedge ACLK); #1 WVALID = 1'b0;
  endtask

  task automatic do_ar(input logic [31:0] a, input logic [2:0] p);
    int n = 0;
    ARADDR = a; ARPROT = p; ARVALID = 1'b1;
    @(negedge ACLK);
    while (!ARREADY && n < 50) begin @(negedge ACLK); n++; end
    if (!ARREADY) chk("ar_ready_timeout", 32'd0, 32'd1);
    @(posedge ACLK); #1 ARVALID = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge ACLK);
    while ((rq_data.size() != 0 || bq_resp.size() != 0 || RVALID || BVALID) && n < 100) begin
      @(negedge ACLK); n++;
    end
    if (n >= 100) chk("idle_timeout", 32'd0, 32'd1);
    @(posedge ACLK); #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                    input logic [2:0] p, input logic [1:0] resp);
    bq_resp.push_back(resp);
    fork
      do_aw(a, p);
      do_w(d, s);
    join
    wait_idle();
  endtask

  task automatic rd(input logic [31:0] a, input logic [2:0] p, input logic [31:0] d,
                    input logic [1:0] resp);
    rq_data.push_back(d);
    rq_resp.push_back(resp);
    do_ar(a, p);
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ARESETN = 1'b0; ARVALID = 1'b0; AWVALID = 1'b0; WVALID = 1'b0;
    RREADY = 1'b1; BREADY = 1'b1;
    ARADDR = '0; ARPROT = '0; AWADDR = '0; AWPROT = '0; WDATA = '0; WSTRB = '0;
    repeat (2) @(posedge ACLK);
    #1 ARESETN = 1'b1;
    @(negedge ACLK);
    chk("rst_rvalid", {31'd0, RVALID}, 32'd0);
    chk("rst_bvalid", {31'd0, BVALID}, 32'd0);
    chk("rst_arready", {31'd0, ARREADY}, 32'd1);
    chk("rst_awready", {31'd0, AWREADY}, 32'd1);
    chk("rst_wready", {31'd0, WREADY}, 32'd1);
    chk("rst_rdata", RDATA, 32'd0);
    chk("rst_rresp", {30'd0, RRESP}, 32'd0);
    chk("rst_bresp", {30'd0, BRESP}, 32'd0);
    @(posedge ACLK); #1;

    // AW and W together: BVALID two edges after the handshake
    bq_resp.push_back(2'b00);
    fork
      do_aw(32'h8000_0004, 3'b000);
      do_w(32'hDEAD_BEEF, 4'hF);
    join
    @(negedge ACLK);
    chk("bvalid_one_edge", {31'd0, BVALID}, 32'd0);
    @(negedge ACLK);
    chk("bvalid_two_edges", {31'd0, BVALID}, 32'd1);
    wait_idle();
    rq_data.push_back(32'hDEAD_BEEF);
    rq_resp.push_back(2'b00);
    do_ar(32'h8000_0004, 3'b000);
    @(negedge ACLK);
    chk("rvalid_latency", {31'd0, RVALID}, 32'd1);
    wait_idle();

    // W ahead of AW with partial strobes
    wr(32'h8000_0008, 32'hAAAA_AAAA, 4'hF, 3'b000, 2'b00);
    bq_resp.push_back(2'b00);
    do_w(32'h1122_3344, 4'b0101);
    repeat (3) begin
      @(negedge ACLK);
      chk("wready_held_low", {31'd0, WREADY}, 32'd0);
    end
    @(posedge ACLK); #1;
    do_aw(32'h8000_0008, 3'b000);
    wait_idle();
    rd(32'h8000_0008, 3'b000, 32'hAA22_AA44, 2'b00);

    // Range boundaries and zero-strobe no-op
    wr(32'h8000_0000, 32'h1234_5678, 4'hF, 3'b000, 2'b00);
    wr(32'h8000_0040, 32'hFFFF_FFFF, 4'hF, 3'b000, 2'b10);
    rd(32'h8000_0000, 3'b000, 32'h1234_5678, 2'b00);
    rd(32'h7FFF_FFFC, 3'b000, 32'h0000_0000, 2'b10);
    rd(32'h8000_0040, 3'b000, 32'h0000_0000, 2'b10);
    wr(32'h8000_0000, 32'h0000_0000, 4'h0, 3'b000, 2'b00);
    rd(32'h8000_0000, 3'b000, 32'h1234_5678, 2'b00);
    wr(32'h8000_003C, 32'h0BAD_CAFE, 4'hF, 3'b000, 2'b00);
    rd(32'h8000_003C, 3'b000, 32'h0BAD_CAFE, 2'b00);

    // R backpressure
    RREADY = 1'b0;
    rq_data.push_back(32'hDEAD_BEEF);
    rq_resp.push_back(2'b00);
    do_ar(32'h8000_0004, 3'b000);
    repeat (5) begin
      @(negedge ACLK);
      chk("rvalid_stall", {31'd0, RVALID}, 32'd1);
      chk("rdata_stall", RDATA, 32'hDEAD_BEEF);
      chk("arready_stall", {31'd0, ARREADY}, 32'd0);
    end
    @(posedge ACLK); #1 RREADY = 1'b1;
    wait_idle();

    // B backpressure
    BREADY = 1'b0;
    bq_resp.push_back(2'b00);
    fork
      do_aw(32'h8000_0014, 3'b000);
      do_w(32'h0000_0077, 4'hF);
    join
    @(posedge ACLK); #1;
    repeat (4) begin
      @(negedge ACLK);
      chk("bvalid_stall", {31'd0, BVALID}, 32'd1);
      chk("awready_stall", {31'd0, AWREADY}, 32'd0);
      chk("wready_stall", {31'd0, WREADY}, 32'd0);
    end
    @(posedge ACLK); #1 BREADY = 1'b1;
    wait_idle();
    @(negedge ACLK);
    chk("awready_after_b", {31'd0, AWREADY}, 32'd1);
    chk("wready_after_b", {31'd0, WREADY}, 32'd1);
    @(posedge ACLK); #1;
    rd(32'h8000_0014, 3'b000, 32'h0000_0077, 2'b00);

    // Read captured at the commit edge sees the old word
    wr(32'h8000_000C, 32'h0000_0000, 4'hF, 3'b000, 2'b00);
    bq_resp.push_back(2'b00);
    rq_data.push_back(32'h0000_0000);
    rq_resp.push_back(2'b00);
    fork
      do_aw(32'h8000_000C, 3'b000);
      do_w(32'h0000_0005, 4'hF);
      begin
        @(posedge ACLK); #1;
        do_ar(32'h8000_000C, 3'b000);
      end
    join
    wait_idle();
    rd(32'h8000_000C, 3'b000, 32'h0000_0005, 2'b00);

    // Reset with only AW buffered
    wr(32'h8000_0010, 32'hCAFE_F00D, 4'hF, 3'b000, 2'b00);
    do_aw(32'h8000_0010, 3'b000);
    @(negedge ACLK);
    chk("awready_aw_buffered", {31'd0, AWREADY}, 32'd0);
    ARESETN = 1'b0;
    @(posedge ACLK); #1 ARESETN = 1'b1;
    repeat (3) begin
      @(negedge ACLK);
      chk("bvalid_after_reset", {31'd0, BVALID}, 32'd0);
      chk("awready_after_reset", {31'd0, AWREADY}, 32'd1);
    end
    @(posedge ACLK); #1;
    rd(32'h8000_0010, 3'b000, 32'hCAFE_F00D, 2'b00);

`ifdef AXIL_SRAM_PROT_CHECK_EN
    wr(32'h8000_0010, 32'hFFFF_FFFF, 4'hF, 3'b010, 2'b10);
    rd(32'h8000_0010, 3'b000, 32'hCAFE_F00D, 2'b00);
    rd(32'h8000_0010, 3'b010, 32'h0000_0000, 2'b10);
`else
    wr(32'h8000_0010, 32'h1357_9BDF, 4'hF, 3'b010, 2'b00);
    rd(32'h8000_0010, 3'b010, 32'h1357_9BDF, 2'b00);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
